// File: rtl/rip_lsu_if.sv
`default_nettype none
// ============================================================================
// rip_lsu_if : CPU-side command/status and memory-bus signals of the LSU
// Revision   : 1.0
// ============================================================================
interface rip_lsu_if;

  // One-hot memory-op flags; a non-memory instruction arrives as all zeros.
  typedef struct packed {
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } inst_t;

  inst_t       inst;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  inst, start, addr, wdata_in, mem_gnt, mem_rvalid, mem_rdata,
    output busy, done, rdata, misaligned,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output inst, start, addr, wdata_in, mem_gnt, mem_rvalid, mem_rdata,
    input  busy, done, rdata, misaligned,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/rip_lsu.sv
`default_nettype none
// ============================================================================
// rip_lsu : single-outstanding load/store unit, IDLE -> REQ -> (WAIT) -> IDLE
// Revision: 1.0
// ============================================================================
module rip_lsu (
  input  wire logic clk,
  input  wire logic rst_n,
  rip_lsu_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;

  logic        is_byte, is_half, is_word, is_store, is_ls, is_mis, is_signed;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign is_byte   = bus.inst.lb | bus.inst.lbu | bus.inst.sb;
  assign is_half   = bus.inst.lh | bus.inst.lhu | bus.inst.sh;
  assign is_word   = bus.inst.lw | bus.inst.sw;
  assign is_store  = bus.inst.sb | bus.inst.sh | bus.inst.sw;
  assign is_signed = bus.inst.lb | bus.inst.lh;
  assign is_ls     = is_byte | is_half | is_word;
  assign is_mis    = (is_half & bus.addr[0]) | (is_word & (bus.addr[1:0] != 2'b00));

  assign req_be    = is_word ? 4'b1111 :
                     is_half ? (4'b0011 << bus.addr[1:0]) :
                               (4'b0001 << bus.addr[1:0]);
  assign req_wdata = is_word ? bus.wdata_in :
                     is_half ? {2{bus.wdata_in[15:0]}} :
                               {4{bus.wdata_in[7:0]}};

  // Lane select uses the offset latched at issue, not the live address.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = bus.mem_rdata[7:0];
      2'd1:    lane_byte = bus.mem_rdata[15:8];
      2'd2:    lane_byte = bus.mem_rdata[23:16];
      default: lane_byte = bus.mem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{sign_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = {{16{sign_q & lane_half[15]}}, lane_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    size_d       = size_q;
    sign_d       = sign_q;
    off_d        = off_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && is_ls) begin
          if (is_mis) begin
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
            size_d      = is_word ? SZ_WORD : (is_half ? SZ_HALF : SZ_BYTE);
            sign_d      = is_signed;
            off_d       = bus.addr[1:0];
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = S_IDLE;
          rdata_d = load_ext;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      done_q       <= 1'b0;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      off_q        <= off_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.misaligned = misaligned_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: doc/rip_lsu.md
RIP_LSU -- requirements
Module: rip_lsu

Interface
REQ-001 Parameter: none; all datapaths fixed at 32 bits, byte-addressed, 4-byte data bus.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 inst  input  inst_t  decoded one-hot instruction flags; LB/LH/LW/LBU/LHU/SB/SH/SW used.
REQ-005 start  input  1  addr and wdata_in valid this cycle for the instruction on inst.
REQ-006 addr  input  32  effective address (registered ALU result).
REQ-007 wdata_in  input  32  store source (rs2).
REQ-008 mem_req  output  1  memory request valid.
REQ-009 mem_we  output  1  1 = write, 0 = read.
REQ-010 mem_addr  output  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-011 mem_be  output  4  byte enables, bit i = byte lane i.
REQ-012 mem_wdata  output  32  lane-replicated store data.
REQ-013 mem_gnt  input  1  memory accepted the request this cycle.
REQ-014 mem_rvalid  input  1  mem_rdata valid; earliest one cycle after the load's gnt.
REQ-015 mem_rdata  input  32  raw read word.
REQ-016 busy  output  1  1 whenever state != IDLE.
REQ-017 done  output  1  one-cycle pulse on access completion.
REQ-018 rdata  output  32  extended load result, valid with done, held until next done.
REQ-019 misaligned  output  1  one-cycle pulse for a rejected misaligned access.

Function
REQ-020 FSM states IDLE, REQ, WAIT; state, mem_* outputs, done, rdata and misaligned are registers.
REQ-021 IDLE: start with no load/store flag set is ignored; start while busy is ignored.
REQ-022 IDLE, start, load/store: misaligned if (LH|LHU|SH) and addr[0], or (LW|SW) and addr[1:0] != 0 -> misaligned=1 next cycle, stay IDLE, mem_req stays 0.
REQ-023 IDLE, start, aligned -> latch width/sign/offset; next cycle state=REQ, mem_req=1, mem_we=store, mem_addr, mem_be, mem_wdata driven.
REQ-024 mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-025 mem_wdata: byte = {4{wdata_in[7:0]}}; half = {2{wdata_in[15:0]}}; word = wdata_in.
REQ-026 REQ: mem_req and all mem_* outputs held stable until mem_gnt=1.
REQ-027 REQ, gnt, store -> next cycle IDLE, mem_req=0, done=1; rdata unchanged.
REQ-028 REQ, gnt, load -> next cycle WAIT, mem_req=0.
REQ-029 WAIT: on mem_rvalid -> select lane by latched offset, sign-extend (LB/LH) or zero-extend (LBU/LHU/LW), register to rdata, done=1 next cycle, state=IDLE.
REQ-030 mem_rvalid outside WAIT is ignored; mem_gnt outside REQ is ignored.
REQ-031 Minimum latency start->done: store 2 cycles, load 3 cycles (gnt same cycle as mem_req, rvalid one cycle later).
REQ-032 start in the done cycle is accepted (FSM already IDLE); back-to-back accesses give one access per 2 (store) / 3 (load) cycles minimum.
REQ-033 No timeout: REQ and WAIT wait indefinitely.

Reset
REQ-034 rst_n=0 at posedge -> state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, done=0, misaligned=0, rdata=0, busy=0.
REQ-035 Reset in REQ or WAIT abandons the access: no done pulse, later rvalid/gnt ignored.

Verification
REQ-036 SW addr=0x100, wdata_in=0xDEADBEEF, gnt at once -> mem_req cycle 1, mem_addr=0x100, be=1111, wdata=0xDEADBEEF, done cycle 2.
REQ-037 SB addr=0x203, wdata_in=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, mem_addr=0x200.
REQ-038 LB addr=0x102, rdata word 0x1280FF00 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102 -> 0x00001280.
REQ-039 LW addr=0x100, gnt delayed 3 cycles -> mem_req held 4 cycles with stable addr/be; rvalid 2 cycles after gnt -> done one cycle after rvalid, busy high throughout.
REQ-040 LW addr=0x102 -> misaligned=1 next cycle, mem_req never asserted, no done; start with ADD flag only -> no activity.
REQ-041 rst_n=0 in WAIT, then mem_rvalid=1 -> no done, rdata=0, busy=0.
